// File: rtl/pid_pkg.sv
// Shared constants for the PID loop: datapath widths, PWM limits and the
// sequencer state codes, so the sequencer and the output stage agree.
package pid_pkg;

  localparam int WIDTH      = 16;
  localparam int PWM_BITS   = 8;
  localparam int PWM_PERIOD = 255;
  // Also the integrator clip value.
  localparam int PWM_MAX    = 181;

  localparam logic [2:0] st_idle      = 3'd0;
  localparam logic [2:0] st_sample    = 3'd1;
  localparam logic [2:0] st_compute_e = 3'd2;
  localparam logic [2:0] st_compute_u = 3'd3;
  localparam logic [2:0] st_update    = 3'd4;

endpackage

// File: rtl/pwm_saturate.sv
// Combinational signed clamp of a WIDTH-bit word into the range 0..MAX,
// returned as an unsigned OUT_BITS-bit value.
module pwm_saturate #(
  parameter int WIDTH    = pid_pkg::WIDTH,
  parameter int OUT_BITS = pid_pkg::PWM_BITS,
  parameter int MAX      = pid_pkg::PWM_MAX
) (
  input  logic signed [WIDTH-1:0]  value,
  output logic        [OUT_BITS-1:0] clamped
);

  localparam logic signed [WIDTH-1:0] MAX_S = WIDTH'(MAX);

  always_comb begin
    clamped = value[OUT_BITS-1:0];
    if (value[WIDTH-1]) begin
      clamped = '0;
    end else if (value > MAX_S) begin
      clamped = OUT_BITS'(MAX);
    end
  end

endmodule

// File: rtl/pwm_output.sv
// PID output stage: clamps the control word, double-buffers it so the duty
// only changes on a period boundary, and drives the registered PWM pin.
module pwm_output #(
  parameter int WIDTH      = pid_pkg::WIDTH,
  parameter int PWM_BITS   = pid_pkg::PWM_BITS,
  parameter int PWM_PERIOD = pid_pkg::PWM_PERIOD,
  parameter int PWM_MAX    = pid_pkg::PWM_MAX,
  parameter int PRESCALE   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] u_in,
  input  logic                    u_valid,
  output logic                    pwm_out,
  output logic signed [WIDTH-1:0] u_prev,
  output logic                    period_done,
  output logic                    pending
);

  import pid_pkg::*;

  // A one-bit prescaler is kept even for PRESCALE == 1; it simply stays at 0.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]     prescale_reg;
  logic [PWM_BITS-1:0] cnt_reg;
  logic [PWM_BITS-1:0] shadow_reg;
  logic [PWM_BITS-1:0] active_reg;
  logic [PWM_BITS-1:0] active_next;
  logic [PWM_BITS-1:0] sat_duty;
  logic                pending_reg;
  logic                pwm_reg;
  logic                period_done_reg;
  logic [WIDTH-1:0]    u_prev_reg;
  logic                tick;
  logic                boundary;

  pwm_saturate #(
    .WIDTH   (WIDTH),
    .OUT_BITS(PWM_BITS),
    .MAX     (PWM_MAX)
  ) u_sat (
    .value  (u_in),
    .clamped(sat_duty)
  );

  assign tick        = enable && (prescale_reg == PS_W'(PRESCALE - 1));
  assign boundary    = tick && (cnt_reg == PWM_BITS'(PWM_PERIOD - 1));
  // The boundary loads the shadow as it was before this edge's capture.
  assign active_next = (boundary && pending_reg) ? shadow_reg : active_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_reg    <= '0;
      cnt_reg         <= '0;
      shadow_reg      <= '0;
      active_reg      <= '0;
      pending_reg     <= 1'b0;
      pwm_reg         <= 1'b0;
      period_done_reg <= 1'b0;
      u_prev_reg      <= '0;
    end else begin
      if (enable) begin
        prescale_reg <= tick ? '0 : prescale_reg + PS_W'(1);
        if (tick) begin
          cnt_reg <= (cnt_reg == PWM_BITS'(PWM_PERIOD - 1)) ? '0
                                                            : cnt_reg + PWM_BITS'(1);
        end
      end else begin
        prescale_reg <= '0;
        cnt_reg      <= '0;
      end

      active_reg <= active_next;

      // A capture on the boundary edge stays pending for the next period.
      if (u_valid) begin
        shadow_reg  <= sat_duty;
        pending_reg <= 1'b1;
      end else if (boundary) begin
        pending_reg <= 1'b0;
      end

      if (boundary) begin
        u_prev_reg <= WIDTH'(active_next);
      end

      period_done_reg <= boundary;
      pwm_reg         <= enable && (cnt_reg < active_reg);
    end
  end

  assign pwm_out     = pwm_reg;
  assign u_prev      = u_prev_reg;
  assign period_done = period_done_reg;
  assign pending     = pending_reg;

endmodule
